// File: rtl/spm_driver.sv
// Host-side driver for one serial-parallel multiplier (spm): accepts signed operand pairs,
// streams y LSB-first into spm, and returns the 2*SIZE-bit product. Option: SPM_DRV_ZERO_SKIP_EN.
module spm_driver #(
    parameter int SIZE = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [SIZE-1:0]     in_x,
    input  logic [SIZE-1:0]     in_y,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [2*SIZE-1:0]   out_p,
    output logic                spm_clr,
    output logic [SIZE-1:0]     spm_x,
    output logic                spm_y,
    input  logic                spm_p
);

    localparam int CW = $clog2(2 * SIZE);
    localparam logic [CW-1:0] CNT_LAST = CW'(2 * SIZE - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLR   = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t                state_r;
    logic [CW-1:0]         cnt_r;
    logic [SIZE-1:0]       y_sr_r;
    logic [2*SIZE-2:0]     p_sr_r;

`ifdef SPM_DRV_ZERO_SKIP_EN
    logic zero_s;
    assign zero_s = (in_x == {SIZE{1'b0}}) || (in_y == {SIZE{1'b0}});
`endif

    // Sequencer: state, operand/product shift registers and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            cnt_r     <= {CW{1'b0}};
            y_sr_r    <= {SIZE{1'b0}};
            p_sr_r    <= {(2*SIZE-1){1'b0}};
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_p     <= {(2*SIZE){1'b0}};
            spm_clr   <= 1'b1;
            spm_x     <= {SIZE{1'b0}};
            spm_y     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        spm_x    <= in_x;
                        y_sr_r   <= in_y;
                        in_ready <= 1'b0;
`ifdef SPM_DRV_ZERO_SKIP_EN
                        if (zero_s) begin
                            state_r   <= DONE;
                            out_p     <= {(2*SIZE){1'b0}};
                            out_valid <= 1'b1;
                        end else begin
                            state_r   <= CLR;
                        end
`else
                        state_r  <= CLR;
`endif
                    end else begin
                        state_r  <= IDLE;
                    end
                end
                CLR: begin
                    state_r <= RUN;
                    cnt_r   <= {CW{1'b0}};
                    spm_clr <= 1'b0;
                    spm_y   <= y_sr_r[0];
                    y_sr_r  <= {y_sr_r[SIZE-1], y_sr_r[SIZE-1:1]};
                end
                RUN: begin
                    // spm_p lags spm_y by one cycle, so nothing is valid in the first RUN cycle
                    if (cnt_r != {CW{1'b0}}) begin
                        p_sr_r <= {spm_p, p_sr_r[2*SIZE-2:1]};
                    end else begin
                        p_sr_r <= p_sr_r;
                    end
                    if (cnt_r == CNT_LAST) begin
                        state_r <= DRAIN;
                        spm_y   <= 1'b0;
                    end else begin
                        spm_y   <= y_sr_r[0];
                        y_sr_r  <= {y_sr_r[SIZE-1], y_sr_r[SIZE-1:1]};
                        cnt_r   <= cnt_r + CNT_ONE;
                    end
                end
                DRAIN: begin
                    state_r   <= DONE;
                    out_p     <= {spm_p, p_sr_r};
                    out_valid <= 1'b1;
                    spm_clr   <= 1'b1;
                end
                DONE: begin
                    if (out_ready) begin
                        state_r   <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end else begin
                        state_r   <= DONE;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    cnt_r     <= {CW{1'b0}};
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    spm_clr   <= 1'b1;
                    spm_y     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spm_driver.sv
// Self-checking bench for spm_driver: behavioural spm model, table-driven products,
// plus backpressure, mid-run reset and zero-operand sequences.
module tb_spm_driver;

    localparam int SIZE = 32;
    localparam int LAT  = 2 * SIZE + 3;

    logic                clk = 1'b0;
    logic                rst;
    logic                in_valid;
    logic                in_ready;
    logic [SIZE-1:0]     in_x;
    logic [SIZE-1:0]     in_y;
    logic                out_valid;
    logic                out_ready;
    logic [2*SIZE-1:0]   out_p;
    logic                spm_clr;
    logic [SIZE-1:0]     spm_x;
    logic                spm_y;
    logic                spm_p;

    int n_total = 0;
    int n_pass  = 0;

    spm_driver #(.SIZE(SIZE)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y),
        .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p),
        .spm_clr(spm_clr), .spm_x(spm_x), .spm_y(spm_y), .spm_p(spm_p)
    );

    always #5 clk = ~clk;

    // Behavioural spm: serial y LSB first, product bit j registered one cycle after y bit j
    logic [63:0] m_acc;
    logic [6:0]  m_pos;
    logic        m_p;
    logic [63:0] x_ext;
    logic [63:0] m_sum;
    assign x_ext = {{SIZE{spm_x[SIZE-1]}}, spm_x};
    assign m_sum = m_acc + (spm_y ? (x_ext << m_pos) : 64'd0);
    assign spm_p = m_p;

    always @(posedge clk) begin
        if (spm_clr) begin
            m_acc <= 64'd0;
            m_pos <= 7'd0;
            m_p   <= 1'b0;
        end else begin
            m_acc <= m_sum;
            m_p   <= m_sum[m_pos[5:0]];
            m_pos <= m_pos + 7'd1;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    // One full transaction; hold>0 keeps out_ready low for that many cycles after out_valid.
    task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic [63:0] exp,
                          input int exp_lat, input int hold);
        int c;
        out_ready = (hold == 0);
        @(negedge clk);
        chk("in_ready_idle", {63'd0, in_ready}, 64'd1);
        in_valid = 1'b1;
        in_x = x;
        in_y = y;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_x = 32'hDEAD_BEEF;
        in_y = 32'hA5A5_5A5A;
        c = 1;
        while (out_valid !== 1'b1 && c < 200) begin
            if (c == 30 && exp_lat > 1) begin
                chk("spm_x_stable", {32'd0, spm_x}, {32'd0, x});
                chk("spm_clr_run", {63'd0, spm_clr}, 64'd0);
            end
            @(posedge clk);
            #1;
            c++;
        end
        chk("latency", 64'(c), 64'(exp_lat));
        chk("out_p", out_p, exp);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk("bp_valid", {63'd0, out_valid}, 64'd1);
            chk("bp_out_p", out_p, exp);
            chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("valid_drop", {63'd0, out_valid}, 64'd0);
        chk("ready_back", {63'd0, in_ready}, 64'd1);
    endtask

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
        logic [63:0] p;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int c;
        vecs[0] = '{32'd3,          32'd5,          64'h0000_0000_0000_000F};
        vecs[1] = '{32'hFFFF_FFFD,  32'd5,          64'hFFFF_FFFF_FFFF_FFF1};
        vecs[2] = '{32'h8000_0000,  32'h8000_0000,  64'h4000_0000_0000_0000};
        vecs[3] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'h0000_0000_0000_0001};
        vecs[4] = '{32'h7FFF_FFFF,  32'h7FFF_FFFF,  64'h3FFF_FFFF_0000_0001};
        vecs[5] = '{32'h7FFF_FFFF,  32'h8000_0000,  64'hC000_0000_8000_0000};
        vecs[6] = '{32'h1234_5678,  32'd1,          64'h0000_0000_1234_5678};
        vecs[7] = '{32'd1000,       32'hFFFF_FFFF,  64'hFFFF_FFFF_FFFF_FC18};

        rst = 1'b1;
        in_valid = 1'b0;
        in_x = 32'd0;
        in_y = 32'd0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
            chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
            chk("rst_spm_clr", {63'd0, spm_clr}, 64'd1);
            chk("rst_out_p", out_p, 64'd0);
        end
        chk("rst_spm_x", {32'd0, spm_x}, 64'd0);
        chk("rst_spm_y", {63'd0, spm_y}, 64'd0);

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].x, vecs[i].y, vecs[i].p, LAT, 0);
        end

        run_op(32'd3, 32'd5, 64'h0000_0000_0000_000F, LAT, 20);

        // Reset pulsed in the middle of RUN
        @(negedge clk);
        in_valid = 1'b1;
        in_x = 32'h1234_5678;
        in_y = 32'h0ABC_DEF1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        c = 1;
        while (c < 30) begin
            @(posedge clk);
            #1;
            c++;
        end
        rst = 1'b1;
        #1;
        chk("mid_rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("mid_rst_out_p", out_p, 64'd0);
        chk("mid_rst_spm_clr", {63'd0, spm_clr}, 64'd1);
        chk("mid_rst_spm_x", {32'd0, spm_x}, 64'd0);
        chk("mid_rst_spm_y", {63'd0, spm_y}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("post_rst_no_valid", {63'd0, out_valid}, 64'd0);
        end
        run_op(32'd7, 32'hFFFF_FFF7, 64'hFFFF_FFFF_FFFF_FFC1, LAT, 0);

`ifdef SPM_DRV_ZERO_SKIP_EN
        run_op(32'd0, 32'h0000_1234, 64'd0, 1, 0);
`else
        run_op(32'd0, 32'h0000_1234, 64'd0, LAT, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/spm_driver.md
# spm_driver

Host-side driver for the `spm` serial-parallel multiplier: it accepts a pair of signed SIZE-bit operands over a valid/ready handshake and drives `spm` with the parallel operand and a serialised second operand. It collects the serial product stream back into a parallel 2·SIZE-bit result, returned over a second valid/ready handshake. It sits between a word-wide datapath and one `spm` instance, and owns that instance's clear.

## Interface
- SIZE, 32, operand width in bits; the product is 2·SIZE bits; SIZE ≥ 2.
- clk  in  1  clock, rising-edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  driver can accept operands.
- in_x  in  SIZE  multiplicand, two's complement.
- in_y  in  SIZE  multiplier, two's complement.
- out_valid  out  1  product valid.
- out_ready  in  1  consumer accepts product.
- out_p  out  2·SIZE  signed product in_x·in_y.
- spm_clr  out  1  registered clear to `spm` rst; glitch-free flop output.
- spm_x  out  SIZE  parallel operand to `spm` x.
- spm_y  out  1  serial operand to `spm` y, LSB first.
- spm_p  in  1  serial product from `spm` p, LSB first.

## Operation
- FSM states: IDLE, CLR, RUN, DRAIN, DONE. Counter `cnt` has width clog2(2·SIZE).
- IDLE: in_ready=1. On in_valid, latch in_x into spm_x and in_y into the y shift register, then go to CLR. On any other cycle, stay in IDLE.
- CLR: one cycle with spm_clr=1. Go to RUN with cnt=0.
- RUN, cycle cnt=k, for k = 0..2·SIZE−1:
  - spm_y = y_sr[0], and y_sr shifts right arithmetically, so y is sign-extended for 2·SIZE bits.
  - For k ≥ 1, spm_p carries product bit k−1; it is shifted into the MSB of p_sr, which shifts right.
  - At k = 2·SIZE−1, go to DRAIN.
- DRAIN: one cycle. spm_y=0. Capture the final bit (product bit 2·SIZE−1). Go to DONE.
- DONE: out_valid=1 and out_p=p_sr, both held stable. When out_ready=1, go to IDLE. Operands are not accepted in DONE.
- spm_clr is a flop decoded from the next state. It is 0 only while in RUN or DRAIN, so `spm` is held cleared in IDLE, CLR and DONE.
- Arithmetic: out_p = in_x·in_y exactly, as a signed 2·SIZE-bit value (the low 2·SIZE bits of the product).
- Reset mid-operation: all state returns to reset values immediately. The in-flight product is discarded and no out_valid is produced.
- in_x and in_y changing after acceptance has no effect.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_p=0, spm_clr=1, spm_x=0, spm_y=0, cnt=0.
- Cycle numbering: the acceptance cycle is cycle 0. CLR is cycle 1, RUN is cycles 2..2·SIZE+1, DRAIN is cycle 2·SIZE+2, and out_valid rises in cycle 2·SIZE+3. For SIZE=32 this is cycle 67.
- out_valid stays high until the cycle in which out_ready=1. In the following cycle, out_valid=0 and in_ready=1.
- Back-to-back throughput: one product per 2·SIZE+4 cycles when out_ready is held at 1.
- spm_y and spm_x change only on rising clk edges. spm_x is stable from CLR through DRAIN.

## Configuration
- SPM_DRV_ZERO_SKIP_EN defined:
  - In IDLE, if in_valid=1 and either in_x=0 or in_y=0, go directly to DONE with out_p=0.
  - out_valid rises in cycle 1. spm_clr stays 1 and spm_y stays 0 throughout.
- Not defined: every operation takes the full CLR/RUN/DRAIN path, with identical timing regardless of operand values.

## Test plan
- Reset, then idle: in_ready=1, out_valid=0, spm_clr=1, out_p=0; these hold across 10 idle cycles.
- SIZE=32, in_x=3, in_y=5, out_ready=1 -> out_valid in cycle 67; out_p=0x000000000000000F; one out_valid cycle only.
- in_x=−3, in_y=5, then in_x=0x80000000, in_y=0x80000000 -> out_p=0xFFFFFFFFFFFFFFF1, then 0x4000000000000000.
- Backpressure: out_ready=0 for 20 cycles after out_valid -> out_p stable and in_ready=0 until out_ready=1; then IDLE next cycle.
- rst pulsed during RUN at cycle 30 -> all outputs return to reset values immediately; the next operation (7·−9) gives out_p=−63 with nominal latency.
- in_x=0, in_y=0x1234, with the macro defined -> out_valid in cycle 1 and out_p=0; without the macro -> out_valid in cycle 67 and out_p=0.
